// File: rtl/rng_stream_sequencer.sv
// TRNG stream sequencer: gates the entropy source, buffers words in a FIFO and frames them onto AXI Stream.
// Optional running checksum of sent words when RNG_SEQ_CHECKSUM_EN is defined.
module rng_stream_sequencer #(
  parameter int FIFO_AW = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        RNG_GO,
  input  logic        RNG_STOP,
  input  logic [31:0] RNG_SEND_BYTES,
  input  logic [31:0] RNG_DMA_BYTES,
  output logic        SRC_EN,
  input  logic [31:0] SRC_DATA,
  input  logic        SRC_VALID,
  output logic        RNG_RUN,
  output logic        RNG_OVER,
  output logic [31:0] RNG_SENT_BYTES,
`ifdef RNG_SEQ_CHECKSUM_EN
  output logic [31:0] RNG_SUM_DATA,
`endif
  output logic [31:0] AXIS_RNG_TDATA,
  output logic        AXIS_RNG_TLAST,
  output logic        AXIS_RNG_TVALID,
  input  logic        AXIS_RNG_TREADY
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH, S_DRAIN} state_e;

  state_e             state_q;
  logic               run_q, src_en_q, over_q;
  logic [31:0]        send_q, dma_q, acc_q, dcnt_q, sent_q;
  logic [FIFO_AW:0]   fill_q;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic               tvalid_q, tlast_q;
  logic [31:0]        tdata_q;
  logic [31:0]        mem [DEPTH];
  logic               tagm [DEPTH];

  logic               go_start, active, pop, push, dma_hit, send_hit;
  logic               stop_run, stop_drain, push_tag, retag, load;
  logic [31:0]        acc_n, dcnt_n, acc_post, dcnt_post;
  logic [FIFO_AW:0]   mem_cnt;

  // fill_q counts every word not yet handshaked, including the one held in the output register.
  always_comb begin
    go_start   = (state_q == S_IDLE) && RNG_GO;
    active     = (state_q == S_RUN) || (state_q == S_FINISH);
    pop        = tvalid_q && AXIS_RNG_TREADY;
    push       = active && SRC_VALID && (!fill_q[FIFO_AW] || pop);
    acc_n      = acc_q + 32'd4;
    dcnt_n     = dcnt_q + 32'd4;
    dma_hit    = push && (dma_q != '0) && (dcnt_n == dma_q);
    send_hit   = push && (send_q != '0) && (acc_n == send_q);
    acc_post   = push ? acc_n : acc_q;
    dcnt_post  = push ? (dma_hit ? 32'd0 : dcnt_n) : dcnt_q;
    stop_run   = (state_q == S_RUN) && RNG_STOP;
    stop_drain = stop_run && ((acc_post == '0) || (dma_q == '0) || (dcnt_post == '0));
    push_tag   = dma_hit || send_hit || (stop_run && (dma_q == '0));
    // A stop that ends the run without a push marks the newest buffered word as last.
    retag      = stop_drain && !push && (acc_q != '0);
    mem_cnt    = fill_q - (FIFO_AW+1)'(tvalid_q);
    load       = (mem_cnt != '0) && (!tvalid_q || pop);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      run_q    <= 1'b0;
      src_en_q <= 1'b0;
      over_q   <= 1'b0;
      send_q   <= '0;
      dma_q    <= '0;
      acc_q    <= '0;
      dcnt_q   <= '0;
      sent_q   <= '0;
      fill_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (RNG_GO) begin
          state_q  <= S_RUN;
          run_q    <= 1'b1;
          src_en_q <= 1'b1;
        end
        S_RUN: begin
          if (send_hit || stop_drain) begin
            state_q  <= S_DRAIN;
            src_en_q <= 1'b0;
          end else if (stop_run) begin
            state_q  <= S_FINISH;
          end
        end
        S_FINISH: if (dma_hit || send_hit) begin
          state_q  <= S_DRAIN;
          src_en_q <= 1'b0;
        end
        S_DRAIN: if (fill_q == '0) begin
          state_q <= S_IDLE;
          run_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase

      if (go_start) begin
        over_q   <= 1'b0;
        sent_q   <= '0;
        acc_q    <= '0;
        dcnt_q   <= '0;
        fill_q   <= '0;
        wptr_q   <= '0;
        rptr_q   <= '0;
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        send_q   <= RNG_SEND_BYTES & 32'hFFFF_FFFC;
        dma_q    <= RNG_DMA_BYTES & 32'hFFFF_FFFC;
      end else begin
        if (push) begin
          wptr_q <= wptr_q + FIFO_AW'(1);
          acc_q  <= acc_n;
          dcnt_q <= dcnt_post;
        end
        if (active && SRC_VALID && !push)
          over_q <= 1'b1;
        fill_q <= fill_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        if (load) begin
          rptr_q   <= rptr_q + FIFO_AW'(1);
          tvalid_q <= 1'b1;
          tdata_q  <= mem[rptr_q];
          tlast_q  <= tagm[rptr_q] || (retag && (mem_cnt == (FIFO_AW+1)'(1)));
        end else if (pop) begin
          tvalid_q <= 1'b0;
        end else if (retag && tvalid_q && (mem_cnt == '0)) begin
          tlast_q  <= 1'b1;
        end
        if (pop)
          sent_q <= sent_q + 32'd4;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wptr_q]  <= SRC_DATA;
      tagm[wptr_q] <= push_tag;
    end
    if (retag && (mem_cnt != '0))
      tagm[wptr_q - FIFO_AW'(1)] <= 1'b1;
  end

`ifdef RNG_SEQ_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)      sum_q <= '0;
    else if (go_start) sum_q <= '0;
    else if (pop)      sum_q <= sum_q + tdata_q;
  end

  assign RNG_SUM_DATA = sum_q;
`endif

  assign SRC_EN          = src_en_q;
  assign RNG_RUN         = run_q;
  assign RNG_OVER        = over_q;
  assign RNG_SENT_BYTES  = sent_q;
  assign AXIS_RNG_TDATA  = tdata_q;
  assign AXIS_RNG_TLAST  = tlast_q;
  assign AXIS_RNG_TVALID = tvalid_q;

endmodule

// File: tb/tb_rng_stream_sequencer.sv
// Randomized bench for rng_stream_sequencer against a queue-based stream model.
module tb_rng_stream_sequencer;

  logic        ACLK = 1'b0, ARESETN = 1'b0;
  logic        RNG_GO = 1'b0, RNG_STOP = 1'b0, SRC_VALID = 1'b0, AXIS_RNG_TREADY = 1'b0;
  logic [31:0] RNG_SEND_BYTES = '0, RNG_DMA_BYTES = '0, SRC_DATA = '0;
  logic        SRC_EN, RNG_RUN, RNG_OVER, AXIS_RNG_TLAST, AXIS_RNG_TVALID;
  logic [31:0] RNG_SENT_BYTES, AXIS_RNG_TDATA;
`ifdef RNG_SEQ_CHECKSUM_EN
  logic [31:0] RNG_SUM_DATA;
`endif

  rng_stream_sequencer #(.FIFO_AW(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .RNG_GO(RNG_GO), .RNG_STOP(RNG_STOP),
    .RNG_SEND_BYTES(RNG_SEND_BYTES), .RNG_DMA_BYTES(RNG_DMA_BYTES),
    .SRC_EN(SRC_EN), .SRC_DATA(SRC_DATA), .SRC_VALID(SRC_VALID),
    .RNG_RUN(RNG_RUN), .RNG_OVER(RNG_OVER), .RNG_SENT_BYTES(RNG_SENT_BYTES),
`ifdef RNG_SEQ_CHECKSUM_EN
    .RNG_SUM_DATA(RNG_SUM_DATA),
`endif
    .AXIS_RNG_TDATA(AXIS_RNG_TDATA), .AXIS_RNG_TLAST(AXIS_RNG_TLAST),
    .AXIS_RNG_TVALID(AXIS_RNG_TVALID), .AXIS_RNG_TREADY(AXIS_RNG_TREADY)
  );

  always #5 ACLK = ~ACLK;

  localparam int M_IDLE = 0, M_RUN = 1, M_FIN = 2, M_DRAIN = 3;

  typedef struct {
    logic [31:0] d;
    bit          last;
    int          stamp;
  } ent_t;

  // Model: every accepted, not yet handshaked word sits in mq; the head is visible once it is one edge old.
  ent_t        mq[$];
  int          m_st, m_cyc;
  int unsigned m_acc, m_send, m_dma;
  logic [31:0] m_sent, m_sum;
  bit          m_over, m_tv;

  int          n_chk = 0, n_err = 0;
  bit          b_last[$];
  logic [31:0] b_data[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_st = M_IDLE; m_acc = 0; m_send = 0; m_dma = 0;
    m_sent = '0; m_sum = '0; m_over = 0; m_tv = 0;
  endtask

  task automatic model_step(input bit go, input bit stop, input bit sv, input logic [31:0] sd, input bit tr);
    bit pop, act, acc_ok, was_empty, dma_b, send_b, lst;
    int nx;
    ent_t e;
    pop = m_tv && tr;
    act = (m_st == M_RUN) || (m_st == M_FIN);
    nx  = m_st;
    if (m_st == M_IDLE) begin
      if (go) begin
        nx = M_RUN;
        m_acc = 0; m_sent = '0; m_sum = '0; m_over = 0;
        m_send = RNG_SEND_BYTES & 32'hFFFF_FFFC;
        m_dma  = RNG_DMA_BYTES & 32'hFFFF_FFFC;
        mq.delete();
      end
    end else begin
      was_empty = (mq.size() == 0);
      acc_ok = act && sv && (mq.size() < 16 || pop);
      if (act && sv && !acc_ok) m_over = 1;
      if (pop) begin
        m_sum  = m_sum + mq[0].d;
        m_sent = m_sent + 32'd4;
        mq.pop_front();
      end
      if (acc_ok) m_acc = m_acc + 4;
      dma_b  = acc_ok && m_dma != 0 && (m_acc % m_dma) == 0;
      send_b = acc_ok && m_send != 0 && m_acc == m_send;
      lst    = dma_b || send_b;
      case (m_st)
        M_RUN: begin
          if (send_b) nx = M_DRAIN;
          else if (stop) begin
            if (m_acc == 0 || m_dma == 0 || (m_acc % m_dma) == 0) begin
              nx = M_DRAIN;
              if (acc_ok) lst = 1;
              else if (mq.size() > 0) mq[mq.size()-1].last = 1;
            end else nx = M_FIN;
          end
        end
        M_FIN:   if (lst) nx = M_DRAIN;
        M_DRAIN: if (was_empty) nx = M_IDLE;
        default: ;
      endcase
      if (acc_ok) begin
        e.d = sd; e.last = lst; e.stamp = m_cyc;
        mq.push_back(e);
      end
    end
    m_st = nx;
    m_tv = (mq.size() > 0) && (mq[0].stamp != m_cyc);
    m_cyc++;
  endtask

  task automatic compare_all();
    chk("src_en", SRC_EN, (m_st == M_RUN || m_st == M_FIN));
    chk("run", RNG_RUN, (m_st != M_IDLE));
    chk("over", RNG_OVER, m_over);
    chk("sent", RNG_SENT_BYTES, m_sent);
    chk("tvalid", AXIS_RNG_TVALID, m_tv);
    if (m_tv) begin
      chk("tdata", AXIS_RNG_TDATA, mq[0].d);
      chk("tlast", AXIS_RNG_TLAST, mq[0].last);
    end
`ifdef RNG_SEQ_CHECKSUM_EN
    chk("sum", RNG_SUM_DATA, m_sum);
`endif
  endtask

  task automatic step(input bit go, input bit stop, input bit sv, input bit tr, input logic [31:0] sd);
    RNG_GO = go; RNG_STOP = stop; SRC_VALID = sv; AXIS_RNG_TREADY = tr; SRC_DATA = sd;
    if (AXIS_RNG_TVALID && tr) begin
      b_last.push_back(AXIS_RNG_TLAST);
      b_data.push_back(AXIS_RNG_TDATA);
    end
    model_step(go, stop, sv, sd, tr);
    @(posedge ACLK);
    @(negedge ACLK);
    compare_all();
  endtask

  task automatic clear_beats();
    b_last.delete();
    b_data.delete();
  endtask

  function automatic bit last_at(input int i);
    if (i < b_last.size()) return b_last[i];
    return 1'b0;
  endfunction

  function automatic logic [31:0] data_at(input int i);
    if (i < b_data.size()) return b_data[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int n_last();
    int n = 0;
    foreach (b_last[i]) n += int'(b_last[i]);
    return n;
  endfunction

  task automatic run_to_idle(input bit sv, input int maxc);
    for (int c = 0; c < maxc && m_st != M_IDLE; c++) step(0, 0, sv, 1, $urandom);
    chk("idle_reached", RNG_RUN, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] w[$];
    int unsigned sb, db;
    bit go_r, stop_r, sv_r, tr_r;

    model_reset();
    m_cyc = 0;
    repeat (3) @(negedge ACLK);
    chk("rst_tvalid", AXIS_RNG_TVALID, 0);
    chk("rst_tlast", AXIS_RNG_TLAST, 0);
    chk("rst_tdata", AXIS_RNG_TDATA, 0);
    chk("rst_run", RNG_RUN, 0);
    chk("rst_over", RNG_OVER, 0);
    chk("rst_src_en", SRC_EN, 0);
    chk("rst_sent", RNG_SENT_BYTES, 0);
    ARESETN = 1'b1;
    step(0, 0, 1, 1, $urandom);

    // Bounded run, two DMA transfers.
    RNG_SEND_BYTES = 64; RNG_DMA_BYTES = 32;
    clear_beats();
    step(1, 0, 0, 1, 0);
    run_to_idle(1, 100);
    chk("s1_beats", b_last.size(), 16);
    chk("s1_tl8", last_at(7), 1);
    chk("s1_tl16", last_at(15), 1);
    chk("s1_ntl", n_last(), 2);
    chk("s1_sent", RNG_SENT_BYTES, 64);
    chk("s1_over", RNG_OVER, 0);

    // Unlimited run stopped mid-transfer; finishes the DMA block.
    RNG_SEND_BYTES = 0; RNG_DMA_BYTES = 16;
    clear_beats();
    step(1, 0, 0, 1, 0);
    for (int c = 0; c < 50 && m_acc < 24; c++) step(0, 0, 1, 1, $urandom);
    step(0, 1, 1, 1, $urandom);
    run_to_idle(1, 100);
    chk("s2_beats", b_last.size(), 8);
    chk("s2_tl4", last_at(3), 1);
    chk("s2_tl8", last_at(7), 1);
    chk("s2_ntl", n_last(), 2);

    // Stalled sink: FIFO fills, overrun, stream stays contiguous.
    RNG_SEND_BYTES = 0; RNG_DMA_BYTES = 0;
    clear_beats();
    w.delete();
    step(1, 0, 0, 1, 0);
    for (int c = 0; c < 40; c++) begin
      logic [31:0] d;
      d = $urandom;
      if (c < 16) w.push_back(d);
      step(0, 0, 1, 0, d);
    end
    chk("s3_over", RNG_OVER, 1);
    chk("s3_hold", AXIS_RNG_TDATA, w[0]);
    step(0, 1, 0, 1, 0);
    run_to_idle(0, 100);
    chk("s3_beats", b_data.size(), 16);
    for (int i = 0; i < 16; i++) chk($sformatf("s3_word%0d", i), data_at(i), w[i]);
    chk("s3_tl_end", last_at(15), 1);
    chk("s3_ntl", n_last(), 1);

    // GO+STOP together starts a run; a second GO mid-run is ignored.
    RNG_SEND_BYTES = 32; RNG_DMA_BYTES = 0;
    step(1, 1, 0, 1, 0);
    chk("s4_run", RNG_RUN, 1);
    for (int c = 0; c < 3; c++) step(0, 0, 1, 1, $urandom);
    step(1, 0, 0, 0, 0);
    chk("s4_go_ign_run", RNG_RUN, 1);
    run_to_idle(1, 100);
    chk("s4_sent", RNG_SENT_BYTES, 32);

    // Asynchronous reset while draining with 5 words queued.
    RNG_SEND_BYTES = 32; RNG_DMA_BYTES = 0;
    step(1, 0, 0, 1, 0);
    for (int c = 0; c < 40 && m_st != M_DRAIN; c++) step(0, 0, 1, 0, $urandom);
    for (int c = 0; c < 3; c++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("s5_pre_sent", RNG_SENT_BYTES, 12);
    #2 ARESETN = 1'b0;
    #1;
    chk("s5_tvalid", AXIS_RNG_TVALID, 0);
    chk("s5_run", RNG_RUN, 0);
    chk("s5_sent", RNG_SENT_BYTES, 0);
    model_reset();
    @(negedge ACLK);
    ARESETN = 1'b1;
    RNG_SEND_BYTES = 16;
    clear_beats();
    step(1, 0, 0, 1, 0);
    run_to_idle(1, 100);
    chk("s5_beats", b_last.size(), 4);
    chk("s5_sent_after", RNG_SENT_BYTES, 16);

`ifdef RNG_SEQ_CHECKSUM_EN
    RNG_SEND_BYTES = 16; RNG_DMA_BYTES = 0;
    step(1, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 1, i);
    run_to_idle(0, 50);
    chk("cs_sum10", RNG_SUM_DATA, 10);
    step(1, 0, 0, 1, 0);
    chk("cs_clear", RNG_SUM_DATA, 0);
    step(0, 1, 0, 1, 0);
    run_to_idle(0, 50);
`endif

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      sb = ($urandom_range(0, 3) == 0) ? 0 : 4 * $urandom_range(1, 30);
      case ($urandom_range(0, 4))
        0: db = 0;
        1: db = 8;
        2: db = 12;
        3: db = 16;
        default: db = 32;
      endcase
      RNG_SEND_BYTES = sb + $urandom_range(0, 3);
      RNG_DMA_BYTES  = db + $urandom_range(0, 3);
      step(1, 0, 0, 1, 0);
      for (int c = 0; c < 400 && m_st != M_IDLE; c++) begin
        go_r   = ($urandom_range(0, 49) == 0);
        stop_r = (c >= 300) || ($urandom_range(0, 29) == 0);
        sv_r   = ($urandom_range(0, 3) != 0);
        tr_r   = (c >= 300) || ($urandom_range(0, 9) < 7);
        step(go_r, stop_r, sv_r, tr_r, $urandom);
      end
      chk("rnd_idle", RNG_RUN, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rng_stream_sequencer.md
Name: rng_stream_sequencer

Overview:
- Sequences the TRNG output datapath between the entropy source and the AXI Stream master port.
- Starts and stops sampling on RNG_GO/RNG_STOP, buffers raw 32-bit words in a small FIFO and counts bytes.
- Frames the stream with TLAST at DMA-transfer boundaries and at end of run.
- Reports run, overrun and sent-byte status to the AXI-Lite control block.

Parameters:
FIFO_AW, 4, log2 of FIFO depth in 32-bit words (depth 16)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset; asynchronous, active-low
RNG_GO  in  1  single-cycle start pulse
RNG_STOP  in  1  single-cycle stop request
RNG_SEND_BYTES  in  32  total bytes per run; bits[1:0] ignored; 0 = unlimited
RNG_DMA_BYTES  in  32  bytes per DMA transfer (TLAST period); bits[1:0] ignored; 0 = no periodic TLAST
SRC_EN  out  1  enables entropy source sampling
SRC_DATA  in  32  raw random word
SRC_VALID  in  1  SRC_DATA valid this cycle; no back-pressure
RNG_RUN  out  1  high while not IDLE
RNG_OVER  out  1  sticky overrun flag
RNG_SENT_BYTES  out  32  bytes handshaked on AXIS this run
AXIS_RNG_TDATA  out  32  stream data
AXIS_RNG_TLAST  out  1  end of DMA transfer / run
AXIS_RNG_TVALID  out  1  stream valid
AXIS_RNG_TREADY  in  1  stream ready

Behaviour:
- Reset (ARESETN low, asynchronous): state IDLE, FIFO empty. SRC_EN, RNG_RUN, RNG_OVER, TVALID and TLAST = 0. RNG_SENT_BYTES and TDATA = 0. Reset mid-run discards the FIFO contents with no TLAST.
- States: IDLE, RUN, FINISH, DRAIN.
- IDLE: RNG_GO -> RUN. On entry to RUN:
  - clear RNG_OVER, RNG_SENT_BYTES, the accepted-byte counter ACC and the DMA counter;
  - flush the FIFO;
  - latch SEND_BYTES and DMA_BYTES.
  - RNG_STOP is ignored in IDLE. If GO and STOP arrive in the same cycle, GO wins.
- RNG_GO outside IDLE: ignored.
- RUN and FINISH:
  - SRC_EN = 1.
  - On SRC_VALID: if the FIFO is not full, or a pop occurs in the same cycle, push the word and ACC += 4. Otherwise drop the word and set RNG_OVER (sticky until next GO).
  - ACC counts accepted words only, so the output stream is contiguous.
- RUN -> DRAIN when the accepted ACC equals a latched SEND_BYTES != 0. This takes priority over STOP.
- RUN + RNG_STOP:
  - -> DRAIN if ACC is 0 or ACC mod DMA_BYTES == 0 (or DMA_BYTES == 0);
  - else -> FINISH.
- FINISH: keeps accepting until ACC reaches the next DMA_BYTES boundary or SEND_BYTES, then -> DRAIN. Further STOPs are ignored.
- DRAIN: SRC_EN = 0, no pushes. -> IDLE in the cycle after the FIFO becomes empty and the last beat has handshaked.
- TLAST marking: a tag bit is stored with each FIFO word at push. It is 1 if, after the push, ACC mod DMA_BYTES == 0 (DMA_BYTES != 0), or ACC == SEND_BYTES (SEND_BYTES != 0), or the push is the last one before DRAIN. A STOP at ACC == 0 sends nothing.
- AXIS rules:
  - TVALID = FIFO not empty; TDATA and TLAST come from the FIFO head (registered).
  - TDATA and TLAST stay stable while TVALID && !TREADY.
  - Each handshake adds 4 to RNG_SENT_BYTES (mod 2^32).
- Latency: a word pushed at edge N is visible on TVALID after edge N+1.
- FIFO:
  - full = count == 2^FIFO_AW; empty = count == 0;
  - simultaneous push and pop leaves count unchanged;
  - pointers wrap modulo depth.
- Counters wrap modulo 2^32 and are unsigned. The unlimited mode (SEND_BYTES = 0) never self-terminates.

Optional Feature:
- Macro RNG_SEQ_CHECKSUM_EN.
- When defined: adds output RNG_SUM_DATA (32). It resets to 0, clears on GO, and on each AXIS handshake += TDATA (mod 2^32).
- When undefined: the port is absent, with no checksum logic.

Test Plan:
- Reset release, then GO with SEND_BYTES=64 and DMA_BYTES=32, source valid every cycle, TREADY=1 -> 16 beats; TLAST on beats 8 and 16; RNG_SENT_BYTES=64; RNG_RUN falls after beat 16; RNG_OVER=0.
- SEND_BYTES=0, DMA_BYTES=16, STOP after 6 words accepted -> FINISH accepts 2 more; 8 beats total; TLAST on beats 4 and 8; return to IDLE.
- TREADY=0 for 40 cycles, source valid every cycle, FIFO_AW=4 -> 16 words buffered and RNG_OVER=1. After TREADY=1, the stream shows consecutive accepted words with no gaps and the dropped words absent. TDATA stays stable while stalled.
- GO and STOP in the same cycle in IDLE -> run starts. A second GO mid-run -> ignored, counters unchanged.
- ARESETN asserted mid-DRAIN with 5 words queued -> TVALID, RNG_RUN and RNG_SENT_BYTES go to 0 immediately (asynchronously). A following GO starts with an empty FIFO.
- With RNG_SEQ_CHECKSUM_EN, sending words 1,2,3,4 (SEND_BYTES=16) -> RNG_SUM_DATA=10; a following GO resets it to 0.
